pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 11 +
 rtl/branch_target_calc.sv | 24 ++
 rtl/pc_sequencer.sv | 94 +++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared processor package: sequencer state encoding
// and the reset fetch address.
package pc_sequencer_pkg;

   localparam logic [1:0] ST_RUN    = 2'b00;
   localparam logic [1:0] ST_FLUSH  = 2'b01;
   localparam logic [1:0] ST_HALTED = 2'b10;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target generation: PC-relative word offset
// or register-absolute, word aligned.
module branch_target_calc #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              target_sel,
   input  logic [15:0]       imm_offset,
   input  logic [ADDR_W-1:0] reg_target,
   output logic [ADDR_W-1:0] target
);

   logic [ADDR_W-1:0] imm_ext;

   // Sign-extend the word offset, scale to bytes, pick the source
   always_comb begin
      imm_ext = ADDR_W'($signed(imm_offset));
      if (target_sel)
         target = {reg_target[ADDR_W-1:2], 2'b00};
      else
         target = pc + (imm_ext << 2);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and RUN/FLUSH/HALTED sequencing
// with call-link capture.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              branchCondn,
   input  logic              targetSel,
   input  logic [15:0]       immOffset,
   input  logic [ADDR_W-1:0] regTarget,
   input  logic              linkEn,
   input  logic              stall,
   input  logic              halt,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pcPlus4,
   output logic [ADDR_W-1:0] linkAddr,
   output logic              linkValid,
   output logic              flush,
   output logic              halted
);

   logic [1:0]        state;
   logic [ADDR_W-1:0] target;

   branch_target_calc #(
      .ADDR_W(ADDR_W)
   ) u_target (
      .pc        (pc),
      .target_sel(targetSel),
      .imm_offset(immOffset),
      .reg_target(regTarget),
      .target    (target)
   );

   // Next sequential fetch address, wraps naturally
   always_comb begin
      pcPlus4 = pc + ADDR_W'(4);
   end

   // Status outputs decode straight from registered state
   always_comb begin
      flush  = (state == ST_FLUSH);
      halted = (state == ST_HALTED);
   end

   // PC, link and state update: halt > stall > branch > increment
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_RUN;
         pc        <= RESET_PC;
         linkAddr  <= '0;
         linkValid <= 1'b0;
      end else begin
         linkValid <= 1'b0;
         case (state)
            ST_RUN: begin
               if (halt) begin
                  state <= ST_HALTED;
               end else if (!stall) begin
                  if (branchCondn) begin
                     pc    <= target;
                     state <= ST_FLUSH;
                     if (linkEn) begin
                        linkAddr  <= pcPlus4;
                        linkValid <= 1'b1;
                     end
                  end else begin
                     pc <= pcPlus4;
                  end
               end
            end
            ST_FLUSH: begin
               if (halt) begin
                  state <= ST_HALTED;
               end else if (!stall) begin
                  pc    <= pcPlus4;
                  state <= ST_RUN;
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule
